i2c_slave_eeprom: RTL and testbench

I2C_SLAVE_EEPROM -- requirements
Module: i2c_slave_eeprom

---
 rtl/i2c_slave_eeprom.sv | 229 ++++++++++++++++++++++
 tb/tb_i2c_slave_eeprom.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_eeprom.sv
// I2C slave with a 16 x 8 register memory. Bus pins are oversampled on CLK.
// Optional feature: define IIC_AUTO_INC_EN to advance the word pointer after every byte written or read.
`timescale 1ns/1ps
module i2c_slave_eeprom #(
  parameter logic [6:0] DEV_ADDR    = 7'b1010000,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       SCL,
  inout  wire        SDA,
  output logic       Wr_Pulse,
  output logic [3:0] Wr_Addr,
  output logic [7:0] Wr_Data,
  output logic       Done_Sig,
  output logic       Busy,
  output logic [3:0] SQ_State
);

`ifdef IIC_AUTO_INC_EN
  localparam logic [3:0] PTR_STEP = 4'd1;
`else
  localparam logic [3:0] PTR_STEP = 4'd0;
`endif

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_DEV      = 4'd1,
    S_ACK_DEV  = 4'd2,
    S_WORD     = 4'd3,
    S_ACK_WORD = 4'd4,
    S_WDATA    = 4'd5,
    S_ACK_WR   = 4'd6,
    S_RDATA    = 4'd7,
    S_MACK     = 4'd8,
    S_IGNORE   = 4'd9
  } state_t;

  logic [SYNC_STAGES-1:0] scl_sync_q;
  logic [SYNC_STAGES-1:0] sda_sync_q;
  logic                   scl_hist_q;
  logic                   sda_hist_q;

  state_t     state_q;
  logic [2:0] bit_cnt_q;
  logic [6:0] shreg_q;
  logic [6:0] tx_q;
  logic       phase_q;
  logic       rw_q;
  logic [3:0] ptr_q;
  logic [7:0] mem_q [16];
  logic       sda_oe_q;
  logic       wr_pulse_q;
  logic [3:0] wr_addr_q;
  logic [7:0] wr_data_q;
  logic       done_q;
  logic       busy_q;

  logic       scl_s;
  logic       sda_s;
  logic       scl_rise_s;
  logic       scl_fall_s;
  logic       start_s;
  logic       stop_s;
  logic [7:0] rx_byte_s;

  // Synchronise both bus lines and keep one history sample for edge detection.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      scl_sync_q <= {SYNC_STAGES{1'b1}};
      sda_sync_q <= {SYNC_STAGES{1'b1}};
      scl_hist_q <= 1'b1;
      sda_hist_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], SCL};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], SDA};
      scl_hist_q <= scl_sync_q[SYNC_STAGES-1];
      sda_hist_q <= sda_sync_q[SYNC_STAGES-1];
    end
  end

  assign scl_s      = scl_sync_q[SYNC_STAGES-1];
  assign sda_s      = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise_s = scl_s & ~scl_hist_q;
  assign scl_fall_s = ~scl_s & scl_hist_q;
  assign start_s    = scl_s & scl_hist_q & sda_hist_q & ~sda_s;
  assign stop_s     = scl_s & scl_hist_q & ~sda_hist_q & sda_s;
  assign rx_byte_s  = {shreg_q, sda_s};

  // Protocol FSM: receive on SCL rise, drive SDA on SCL fall, phase_q splits each ACK/MACK slot.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= 3'd0;
      shreg_q    <= 7'd0;
      tx_q       <= 7'd0;
      phase_q    <= 1'b0;
      rw_q       <= 1'b0;
      ptr_q      <= 4'd0;
      sda_oe_q   <= 1'b0;
      wr_pulse_q <= 1'b0;
      wr_addr_q  <= 4'd0;
      wr_data_q  <= 8'h00;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else begin
      wr_pulse_q <= 1'b0;
      done_q     <= stop_s;
      busy_q     <= (state_q != S_IDLE) && (state_q != S_IGNORE);
      if (start_s) begin
        state_q   <= S_DEV;
        bit_cnt_q <= 3'd0;
        phase_q   <= 1'b0;
        sda_oe_q  <= 1'b0;
      end else if (stop_s) begin
        state_q   <= S_IDLE;
        bit_cnt_q <= 3'd0;
        phase_q   <= 1'b0;
        sda_oe_q  <= 1'b0;
      end else begin
        case (state_q)
          S_DEV, S_WORD, S_WDATA: begin
            if (scl_rise_s) begin
              shreg_q   <= rx_byte_s[6:0];
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                phase_q <= 1'b0;
                case (state_q)
                  S_DEV: begin
                    if (rx_byte_s[7:1] == DEV_ADDR) begin
                      rw_q    <= rx_byte_s[0];
                      state_q <= S_ACK_DEV;
                    end else begin
                      state_q <= S_IGNORE;
                    end
                  end
                  S_WORD: begin
                    ptr_q   <= rx_byte_s[3:0];
                    state_q <= S_ACK_WORD;
                  end
                  default: begin
                    mem_q[ptr_q] <= rx_byte_s;
                    wr_pulse_q   <= 1'b1;
                    wr_addr_q    <= ptr_q;
                    wr_data_q    <= rx_byte_s;
                    ptr_q        <= ptr_q + PTR_STEP;
                    state_q      <= S_ACK_WR;
                  end
                endcase
              end
            end
          end
          S_ACK_DEV, S_ACK_WORD, S_ACK_WR: begin
            if (scl_fall_s) begin
              if (!phase_q) begin
                sda_oe_q <= 1'b1;
                phase_q  <= 1'b1;
              end else begin
                phase_q   <= 1'b0;
                bit_cnt_q <= 3'd0;
                if ((state_q == S_ACK_DEV) && rw_q) begin
                  tx_q     <= mem_q[ptr_q][6:0];
                  sda_oe_q <= ~mem_q[ptr_q][7];
                  ptr_q    <= ptr_q + PTR_STEP;
                  state_q  <= S_RDATA;
                end else begin
                  sda_oe_q <= 1'b0;
                  state_q  <= (state_q == S_ACK_DEV) ? S_WORD : S_WDATA;
                end
              end
            end
          end
          S_RDATA: begin
            if (scl_fall_s) begin
              sda_oe_q <= ~tx_q[6];
              tx_q     <= {tx_q[5:0], 1'b0};
            end else if (scl_rise_s) begin
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                phase_q <= 1'b0;
                state_q <= S_MACK;
              end
            end
          end
          S_MACK: begin
            // First fall frees the line for the master; the next fall starts the following byte.
            if (scl_fall_s) begin
              if (!phase_q) begin
                sda_oe_q <= 1'b0;
              end else begin
                phase_q   <= 1'b0;
                bit_cnt_q <= 3'd0;
                tx_q      <= mem_q[ptr_q][6:0];
                sda_oe_q  <= ~mem_q[ptr_q][7];
                ptr_q     <= ptr_q + PTR_STEP;
                state_q   <= S_RDATA;
              end
            end else if (scl_rise_s && !phase_q) begin
              if (sda_s) begin
                state_q <= S_IGNORE;
              end else begin
                phase_q <= 1'b1;
              end
            end
          end
          S_IDLE, S_IGNORE: begin
            sda_oe_q <= 1'b0;
          end
          default: begin
            state_q  <= S_IDLE;
            sda_oe_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign SDA      = sda_oe_q ? 1'b0 : 1'bz;
  assign Wr_Pulse = wr_pulse_q;
  assign Wr_Addr  = wr_addr_q;
  assign Wr_Data  = wr_data_q;
  assign Done_Sig = done_q;
  assign Busy     = busy_q;
  assign SQ_State = state_q;

endmodule

// File: tb/tb_i2c_slave_eeprom.sv
// Randomised bench for i2c_slave_eeprom: a bus-level master against a memory/pointer reference model.
`timescale 1ns/1ps
module tb_i2c_slave_eeprom;

  localparam int Q = 50;

`ifdef IIC_AUTO_INC_EN
  localparam logic [3:0] INC = 4'd1;
`else
  localparam logic [3:0] INC = 4'd0;
`endif

  logic       clk      = 1'b0;
  logic       rst      = 1'b1;
  logic       scl_m    = 1'b1;
  logic       sda_oe_m = 1'b0;
  wire        sda_w;
  logic       wr_pulse;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       done;
  logic       busy;
  logic [3:0] sq_state;

  assign sda_w = sda_oe_m ? 1'b0 : 1'bz;
  pullup (sda_w);

  always #5 clk = ~clk;

  i2c_slave_eeprom dut (
    .CLK      (clk),
    .RST      (rst),
    .SCL      (scl_m),
    .SDA      (sda_w),
    .Wr_Pulse (wr_pulse),
    .Wr_Addr  (wr_addr),
    .Wr_Data  (wr_data),
    .Done_Sig (done),
    .Busy     (busy),
    .SQ_State (sq_state)
  );

  int         wr_cnt   = 0;
  int         done_cnt = 0;
  logic [3:0] last_wa  = 4'd0;
  logic [7:0] last_wd  = 8'h00;

  always @(posedge clk) begin
    #2;
    if (wr_pulse) begin
      wr_cnt  <= wr_cnt + 1;
      last_wa <= wr_addr;
      last_wd <= wr_data;
    end
    if (done) done_cnt <= done_cnt + 1;
  end

  logic [7:0] mem_m [16];
  logic [3:0] ptr_m;
  logic [7:0] wq [$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mem_m[i] = 8'h00;
    ptr_m = 4'd0;
  endtask

  task automatic clk_bit(input logic b, output logic r);
    sda_oe_m = ~b;
    #(Q); scl_m = 1'b1;
    #(Q); r = sda_w;
    #(Q); scl_m = 1'b0;
    #(Q);
  endtask

  task automatic i2c_start();
    sda_oe_m = 1'b0;
    #(Q); scl_m = 1'b1;
    #(Q); sda_oe_m = 1'b1;
    #(Q); scl_m = 1'b0;
    #(Q);
  endtask

  task automatic i2c_stop();
    sda_oe_m = 1'b1;
    #(Q); scl_m = 1'b1;
    #(Q); sda_oe_m = 1'b0;
    #(2*Q);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) clk_bit(b[i], r);
    clk_bit(1'b1, r);
    ack = ~r;
  endtask

  task automatic recv_byte(input logic nack, output logic [7:0] b);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, r);
      b[i] = r;
    end
    clk_bit(nack, r);
  endtask

  task automatic finish_xfer();
    int dc0;
    dc0 = done_cnt;
    i2c_stop();
    #(2*Q);
    chk("done_pulse", 32'(done_cnt), 32'(dc0 + 1));
    chk("busy_low", 32'(busy), 32'd0);
  endtask

  task automatic do_write(input logic [7:0] word);
    logic       ack;
    logic [7:0] d;
    int         wc0;
    i2c_start();
    send_byte(8'hA0, ack);
    chk("wr_dev_ack", 32'(ack), 32'd1);
    chk("busy_high", 32'(busy), 32'd1);
    send_byte(word, ack);
    chk("wr_word_ack", 32'(ack), 32'd1);
    ptr_m = word[3:0];
    while (wq.size() > 0) begin
      d   = wq.pop_front();
      wc0 = wr_cnt;
      send_byte(d, ack);
      chk("wr_data_ack", 32'(ack), 32'd1);
      chk("wr_pulse_cnt", 32'(wr_cnt), 32'(wc0 + 1));
      chk("wr_addr", 32'(last_wa), 32'(ptr_m));
      chk("wr_data", 32'(last_wd), 32'(d));
      mem_m[ptr_m] = d;
      ptr_m = ptr_m + INC;
    end
    finish_xfer();
  endtask

  task automatic do_read(input logic [7:0] word, input int n, output logic [7:0] first);
    logic       ack;
    logic [7:0] d;
    i2c_start();
    send_byte(8'hA0, ack);
    chk("rd_dev_ack", 32'(ack), 32'd1);
    send_byte(word, ack);
    chk("rd_word_ack", 32'(ack), 32'd1);
    ptr_m = word[3:0];
    i2c_start();
    send_byte(8'hA1, ack);
    chk("rd_rdev_ack", 32'(ack), 32'd1);
    first = 8'h00;
    for (int k = 0; k < n; k++) begin
      recv_byte(k == n - 1, d);
      if (k == 0) first = d;
      chk("rd_data", 32'(d), 32'(mem_m[ptr_m]));
      ptr_m = ptr_m + INC;
    end
    finish_xfer();
  endtask

  task automatic do_cur_read();
    logic       ack;
    logic [7:0] d;
    i2c_start();
    send_byte(8'hA1, ack);
    chk("cur_dev_ack", 32'(ack), 32'd1);
    recv_byte(1'b1, d);
    chk("cur_rd_data", 32'(d), 32'(mem_m[ptr_m]));
    ptr_m = ptr_m + INC;
    finish_xfer();
  endtask

  task automatic do_bad_addr(input logic [7:0] dev);
    logic ack;
    int   wc0;
    wc0 = wr_cnt;
    i2c_start();
    send_byte(dev, ack);
    chk("bad_dev_noack", 32'(ack), 32'd0);
    chk("bad_dev_busy", 32'(busy), 32'd0);
    send_byte(8'($urandom), ack);
    chk("ignore_noack", 32'(ack), 32'd0);
    finish_xfer();
    chk("bad_dev_nowr", 32'(wr_cnt), 32'(wc0));
  endtask

  task automatic do_abort(input logic [7:0] word, input int nbits);
    logic ack;
    logic r;
    int   wc0;
    wc0 = wr_cnt;
    i2c_start();
    send_byte(8'hA0, ack);
    chk("ab_dev_ack", 32'(ack), 32'd1);
    send_byte(word, ack);
    chk("ab_word_ack", 32'(ack), 32'd1);
    ptr_m = word[3:0];
    for (int i = 0; i < nbits; i++) clk_bit(1'($urandom), r);
    finish_xfer();
    chk("ab_nowr", 32'(wr_cnt), 32'(wc0));
  endtask

  initial begin
    logic [7:0] rd;
    logic [7:0] dev;
    logic       r;
    int         op;
    model_reset();

    #20;
    chk("rst_wr_pulse", 32'(wr_pulse), 32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("rst_wr_data", 32'(wr_data), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_state", 32'(sq_state), 32'd0);
    chk("rst_sda", 32'(sda_w), 32'd1);
    #80; rst = 1'b0;
    #(2*Q);

    // Single write then random read of the same location.
    wq.push_back(8'h5A);
    do_write(8'h03);
    chk("w35_once", 32'(wr_cnt), 32'd1);
    chk("w35_addr", 32'(last_wa), 32'd3);
    chk("w35_data", 32'(last_wd), 32'h5A);
    do_read(8'h03, 1, rd);
    chk("r35_value", 32'(rd), 32'h5A);

    do_abort(8'h02, 4);
    do_read(8'h02, 1, rd);
    chk("abort_mem2", 32'(rd), 32'h00);

    do_bad_addr(8'hA2);

    // Pointer wrap / overwrite behaviour at the top address.
    wq.push_back(8'h11);
    wq.push_back(8'h22);
    do_write(8'h0F);
    do_read(8'h0F, 1, rd);
`ifdef IIC_AUTO_INC_EN
    chk("wrap_mem15", 32'(rd), 32'h11);
    do_read(8'h00, 1, rd);
    chk("wrap_mem0", 32'(rd), 32'h22);
`else
    chk("fixed_mem15", 32'(rd), 32'h22);
    do_read(8'h00, 1, rd);
    chk("fixed_mem0", 32'(rd), 32'h00);
`endif

    // Reset while the slave holds the address ACK low.
    dev = 8'hA0;
    i2c_start();
    for (int i = 7; i >= 0; i--) clk_bit(dev[i], r);
    sda_oe_m = 1'b0;
    #(Q);
    chk("ack_driven", 32'(sda_w), 32'd0);
    rst = 1'b1;
    #1;
    chk("rst_sda_release", 32'(sda_w), 32'd1);
    chk("rst_mid_state", 32'(sq_state), 32'd0);
    #(Q-1);
    rst = 1'b0;
    scl_m = 1'b1;
    #(2*Q);
    model_reset();
    do_cur_read();
    wq.push_back(8'hC3);
    do_write(8'h07);
    do_read(8'h07, 1, rd);

    for (int it = 0; it < 16; it++) begin
      op = $urandom_range(0, 3);
      case (op)
        0: begin
          for (int k = 0; k < $urandom_range(1, 3); k++) wq.push_back(8'($urandom));
          do_write(8'($urandom));
        end
        1: do_read(8'($urandom), $urandom_range(1, 3), rd);
        2: begin
          dev = 8'($urandom);
          if (dev[7:1] == 7'h50) dev[7:1] = 7'h51;
          do_bad_addr(dev);
        end
        default: do_abort(8'($urandom), $urandom_range(1, 6));
      endcase
    end

    for (int a = 0; a < 16; a++) do_read(8'(a), 1, rd);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
